// File: rtl/sd_cmd_responder.sv
// SD-card SPI-mode command responder: decodes frames from SpiReceiver, tracks init state, shifts R1/R7 out on SPI_DO.
// Optional debug ports io___state/io___counter/io___buffer are enabled with `define SD_RESP_DEBUG_EN.
//
// state  | meaning
// IDLE   | waiting for a frame with CS low
// DECODE | one cycle: update card state, build response, load shifter
// NCR    | holding DO=1 for NCR_BYTES*8 falling-edge slots
// SEND   | shifting the response MSB-first on SPI_CLK falling edges
module sd_cmd_responder #(
    parameter int NCR_BYTES    = 1,
    parameter int INIT_RETRIES = 2,
    parameter int MAX_BLOCKLEN = 512
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_SPI_CLK,
    input  logic        io_SPI_CS,
    input  logic        io_ArgumentReadFinished,
    input  logic        io_ReadSuccess,
    input  logic [5:0]  io_Command,
    input  logic [31:0] io_CommandArgument,
    output logic        io_SPI_DO,
    output logic        io_Busy,
    output logic        io_InIdle,
    output logic        io_AppCmd,
    output logic [9:0]  io_BlockLen,
    output logic        io_Overrun
`ifdef SD_RESP_DEBUG_EN
    ,
    output logic [2:0]  io___state,
    output logic [2:0]  io___counter,
    output logic [7:0]  io___buffer
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_NCR    = 3'd2,
        ST_SEND   = 3'd3
    } state_t;

    localparam logic [3:0] LP_RETRIES  = 4'(INIT_RETRIES);
    localparam logic [2:0] LP_NCR_LAST = 3'(NCR_BYTES - 1);

    state_t      r_state;
    logic        r_clk_prev;
    logic        r_arf_prev;
    logic [5:0]  r_cmd;
    logic [31:0] r_arg;
    logic        r_ok;
    logic        r_do;
    logic        r_busy;
    logic        r_idle;
    logic        r_app;
    logic [9:0]  r_blocklen;
    logic        r_overrun;
    logic [3:0]  r_retry;
    logic [39:0] r_shift;
    logic [2:0]  r_byte_cnt;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  r_last_byte;

    logic        w_fall;
    logic        w_frame;
    logic        w_abort;
    logic [7:0]  w_r1;
    logic        w_is_r7;
    logic        w_idle_n;
    logic        w_app_n;
    logic [3:0]  w_retry_n;
    logic [9:0]  w_blen_n;
    logic [39:0] w_resp;

    assign w_fall  = r_clk_prev & ~io_SPI_CLK;
    assign w_frame = ~r_arf_prev & io_ArgumentReadFinished;
    assign w_abort = io_SPI_CS;

    always_comb begin
        w_r1      = 8'h00;
        w_is_r7   = 1'b0;
        w_idle_n  = r_idle;
        w_app_n   = 1'b0;
        w_retry_n = r_retry;
        w_blen_n  = r_blocklen;
        if (!r_ok) begin
            w_r1 = {4'b0000, 1'b1, 2'b00, r_idle};
        end else begin
            case (r_cmd)
                6'd0: begin
                    w_idle_n  = 1'b1;
                    w_retry_n = 4'd0;
                    w_r1      = 8'h01;
                end
                6'd8: begin
                    w_is_r7 = 1'b1;
                    w_r1    = {7'b0, r_idle};
                end
                6'd55: begin
                    w_app_n = 1'b1;
                    w_r1    = {7'b0, r_idle};
                end
                6'd41: begin
                    if (r_app) begin
                        w_retry_n = (r_retry == LP_RETRIES) ? r_retry : r_retry + 4'd1;
                        if (w_retry_n == LP_RETRIES) begin
                            w_idle_n = 1'b0;
                        end
                        w_r1 = {7'b0, w_idle_n};
                    end else begin
                        w_r1 = {5'b00000, 1'b1, 1'b0, r_idle};
                    end
                end
                6'd16: begin
                    if (r_arg >= 32'd1 && r_arg <= 32'(MAX_BLOCKLEN)) begin
                        w_blen_n = r_arg[9:0];
                        w_r1     = {7'b0, r_idle};
                    end else begin
                        w_r1 = {1'b0, 1'b1, 5'b00000, r_idle};
                    end
                end
                default: begin
                    w_r1 = {5'b00000, 1'b1, 1'b0, r_idle};
                end
            endcase
        end
        // R1 is left-aligned so the shifter always emits from bit 39
        w_resp = w_is_r7 ? {w_r1, 16'h0000, 4'h0, r_arg[11:8], r_arg[7:0]}
                         : {w_r1, 32'hFFFF_FFFF};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_clk_prev  <= 1'b0;
            r_arf_prev  <= 1'b0;
            r_cmd       <= 6'd0;
            r_arg       <= 32'd0;
            r_ok        <= 1'b0;
            r_do        <= 1'b1;
            r_busy      <= 1'b0;
            r_idle      <= 1'b1;
            r_app       <= 1'b0;
            r_blocklen  <= 10'd512;
            r_overrun   <= 1'b0;
            r_retry     <= 4'd0;
            r_shift     <= '1;
            r_byte_cnt  <= 3'd0;
            r_bit_cnt   <= 3'd0;
            r_last_byte <= 3'd0;
        end else begin
            r_clk_prev <= io_SPI_CLK;
            r_arf_prev <= io_ArgumentReadFinished;
            r_overrun  <= w_frame & r_busy;
            case (r_state)
                ST_IDLE: begin
                    r_do <= 1'b1;
                    if (w_frame && !io_SPI_CS) begin
                        r_cmd   <= io_Command;
                        r_arg   <= io_CommandArgument;
                        r_ok    <= io_ReadSuccess;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_idle      <= w_idle_n;
                    r_app       <= w_app_n;
                    r_retry     <= w_retry_n;
                    r_blocklen  <= w_blen_n;
                    r_shift     <= w_resp;
                    r_last_byte <= w_is_r7 ? 3'd4 : 3'd0;
                    r_busy      <= 1'b1;
                    r_do        <= 1'b1;
                    r_byte_cnt  <= 3'd0;
                    // a falling edge here already closes the first NCR slot
                    r_bit_cnt   <= w_fall ? 3'd1 : 3'd0;
                    r_state     <= ST_NCR;
                end
                ST_NCR: begin
                    if (w_abort) begin
                        r_do    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_fall) begin
                        if (r_bit_cnt == 3'd7 && r_byte_cnt == LP_NCR_LAST) begin
                            r_do       <= r_shift[39];
                            r_shift    <= {r_shift[38:0], 1'b1};
                            r_bit_cnt  <= 3'd0;
                            r_byte_cnt <= 3'd0;
                            r_state    <= ST_SEND;
                        end else if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt  <= 3'd0;
                            r_byte_cnt <= r_byte_cnt + 3'd1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                ST_SEND: begin
                    if (w_abort) begin
                        r_do    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_fall) begin
                        if (r_bit_cnt == 3'd7 && r_byte_cnt == r_last_byte) begin
                            r_do    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_do    <= r_shift[39];
                            r_shift <= {r_shift[38:0], 1'b1};
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt  <= 3'd0;
                                r_byte_cnt <= r_byte_cnt + 3'd1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                end
                default: begin
                    r_do    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_SPI_DO   = r_do;
    assign io_Busy     = r_busy;
    assign io_InIdle   = r_idle;
    assign io_AppCmd   = r_app;
    assign io_BlockLen = r_blocklen;
    assign io_Overrun  = r_overrun;

`ifdef SD_RESP_DEBUG_EN
    assign io___state   = r_state;
    assign io___counter = r_bit_cnt;
    assign io___buffer  = r_shift[39:32];
`endif

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Scoreboard bench for sd_cmd_responder: expected SPI bit streams are queued at stimulus time
// and compared by a monitor whenever io_Busy falls.
module tb_sd_cmd_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        spi_clk;
    logic        cs;
    logic        arf;
    logic        rs;
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic        do_o;
    logic        busy;
    logic        in_idle;
    logic        app_cmd;
    logic [9:0]  blen;
    logic        overrun;

    sd_cmd_responder dut (
        .clock                   (clock),
        .reset                   (reset),
        .io_SPI_CLK              (spi_clk),
        .io_SPI_CS               (cs),
        .io_ArgumentReadFinished (arf),
        .io_ReadSuccess          (rs),
        .io_Command              (cmd),
        .io_CommandArgument      (arg),
        .io_SPI_DO               (do_o),
        .io_Busy                 (busy),
        .io_InIdle               (in_idle),
        .io_AppCmd               (app_cmd),
        .io_BlockLen             (blen),
        .io_Overrun              (overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] val;
        int          len;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_cur;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] col = 64'd0;
    int          col_n = 0;
    logic        prev_busy = 1'b0;
    int          ov_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // host samples DO on rising SPI_CLK while a response is pending
    always @(posedge spi_clk) begin
        if (cs === 1'b0 && busy === 1'b1) begin
            col = {col[62:0], do_o};
            col_n++;
        end
    end

    always @(negedge clock) begin
        if (prev_busy === 1'b1 && busy === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected actual=%0h bits=%0d required=none", col, col_n);
            end else begin
                e_cur = exp_q.pop_front();
                if (col_n != e_cur.len || col !== e_cur.val) begin
                    errors++;
                    $display("FAIL resp_stream actual=%0h bits=%0d required=%0h bits=%0d",
                             col, col_n, e_cur.val, e_cur.len);
                end
            end
            col   = 64'd0;
            col_n = 0;
        end
        prev_busy = busy;
    end

    always @(negedge clock) begin
        if (overrun === 1'b1) ov_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [63:0] v, input int l);
        exp_t e;
        e.val = v;
        e.len = l;
        exp_q.push_back(e);
    endtask

    task automatic frame(input logic [5:0] c, input logic [31:0] a, input logic ok);
        @(negedge clock);
        cmd = c;
        arg = a;
        rs  = ok;
        arf = 1'b1;
        @(negedge clock);
        arf = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic spi(input int n);
        repeat (n) begin
            spi_clk = 1'b1;
            repeat (2) @(negedge clock);
            spi_clk = 1'b0;
            repeat (2) @(negedge clock);
        end
    endtask

    task automatic r1(input logic [5:0] c, input logic [31:0] a, input logic [7:0] req);
        push({48'h0, 8'hFF, req}, 16);
        frame(c, a, 1'b1);
        spi(16);
    endtask

    initial begin
        reset = 1'b1; cs = 1'b1; spi_clk = 1'b0; arf = 1'b0; rs = 1'b0; cmd = 6'd0; arg = 32'd0;
        repeat (3) @(negedge clock);
        check("rst_do", do_o, 1);
        check("rst_busy", busy, 0);
        check("rst_idle", in_idle, 1);
        check("rst_app", app_cmd, 0);
        check("rst_blen", blen, 512);
        check("rst_overrun", overrun, 0);
        reset = 1'b0;
        @(negedge clock);
        cs = 1'b0;
        @(negedge clock);

        r1(6'd0, 32'd0, 8'h01);
        check("cmd0_idle", in_idle, 1);
        check("cmd0_busy", busy, 0);

        push({16'h0, 48'hFF_01_00_00_01_AA}, 48);
        frame(6'd8, 32'h0000_01AA, 1'b1);
        spi(48);

        r1(6'd55, 32'd0, 8'h01);
        check("cmd55_app", app_cmd, 1);
        r1(6'd41, 32'd0, 8'h01);
        check("acmd41a_app", app_cmd, 0);
        check("acmd41a_idle", in_idle, 1);
        r1(6'd55, 32'd0, 8'h01);
        r1(6'd41, 32'd0, 8'h00);
        check("acmd41b_idle", in_idle, 0);
        check("acmd41b_app", app_cmd, 0);
        r1(6'd41, 32'd0, 8'h04);

        r1(6'd16, 32'd512, 8'h00);
        check("cmd16_512", blen, 512);
        r1(6'd16, 32'd256, 8'h00);
        check("cmd16_256", blen, 256);
        r1(6'd16, 32'd1024, 8'h40);
        check("cmd16_1024", blen, 256);
        r1(6'd16, 32'd0, 8'h40);
        check("cmd16_0", blen, 256);
        r1(6'd33, 32'd0, 8'h04);

        r1(6'd0, 32'd0, 8'h01);
        ov_cnt = 0;
        push({48'h0, 8'hFF, 8'h09}, 16);
        frame(6'd17, 32'd0, 1'b0);
        spi(10);
        frame(6'd55, 32'd0, 1'b1);
        spi(6);
        check("overrun_pulses", ov_cnt, 1);
        check("overrun_dropped_app", app_cmd, 0);

        r1(6'd55, 32'd0, 8'h01);
        check("crcerr_pre_app", app_cmd, 1);
        push({48'h0, 8'hFF, 8'h09}, 16);
        frame(6'd17, 32'd0, 1'b0);
        spi(16);
        check("crcerr_app_clr", app_cmd, 0);

        push({44'h0, 20'hFF010}, 20);
        frame(6'd8, 32'h0000_01AA, 1'b1);
        spi(20);
        @(negedge clock);
        cs = 1'b1;
        @(negedge clock);
        check("abort_do", do_o, 1);
        check("abort_busy", busy, 0);
        repeat (2) @(negedge clock);
        cs = 1'b0;
        @(negedge clock);

        push({52'h0, 12'hFF0}, 12);
        frame(6'd55, 32'd0, 1'b1);
        spi(12);
        check("prerst_app", app_cmd, 1);
        #3 reset = 1'b1;
        #1;
        check("arst_do", do_o, 1);
        check("arst_busy", busy, 0);
        check("arst_idle", in_idle, 1);
        check("arst_app", app_cmd, 0);
        check("arst_blen", blen, 512);
        check("arst_overrun", overrun, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("queue_drained", exp_q.size(), 0);
        check("final_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
